// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffered UART receiver with mid-bit sampling, start-glitch rejection and an RX FIFO.
// Optional feature macro UART_RX_PARITY_EN adds an even-parity bit between the data and stop bits.
module uart_rx_fifo #(
  parameter logic [31:0] DEFAULT_DIV = 32'd16,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ser_rx,
  input  logic [3:0]                  reg_div_we,
  input  logic [31:0]                 reg_div_di,
  output logic [31:0]                 reg_div_do,
  input  logic                        reg_dat_re,
  output logic [31:0]                 reg_dat_do,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        rx_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_WAITHI = 3'd5
  } state_e;

`ifdef UART_RX_PARITY_EN
  localparam state_e DATA_NEXT = S_PARITY;

  function automatic logic even_parity8(input logic [7:0] d);
    return ^d;
  endfunction
`else
  localparam state_e DATA_NEXT = S_STOP;
`endif

  logic         sync1_q, sync2_q, rx_s;
  logic [31:0]  cfg_div_q, cfg_div_d;
  state_e       state_q, state_d, fsm_next_s;
  logic [31:0]  divcnt_q, divcnt_d;
  logic [2:0]   bitidx_q, bitidx_d;
  logic [7:0]   shreg_q, shreg_d;
  logic         perr_q, perr_d;
  logic         sample_s, push_s;
  logic [9:0]   push_word_s;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overrun_q, overrun_d, irq_q;
  logic          empty_s, full_s, pop_s, wr_en_s, drop_s;
  logic [9:0]    head_s;

  // Two-flop synchroniser; flops reset high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= ser_rx;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s = sync2_q;

  // Divider byte-lane merge.
  always_comb begin
    cfg_div_d = cfg_div_q;
    for (int i = 0; i < 4; i++) begin
      if (reg_div_we[i]) cfg_div_d[8*i +: 8] = reg_div_di[8*i +: 8];
      else               cfg_div_d[8*i +: 8] = cfg_div_q[8*i +: 8];
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_div_q <= DEFAULT_DIV;
      state_q   <= S_IDLE;
      divcnt_q  <= 32'd0;
      bitidx_q  <= 3'd0;
      shreg_q   <= 8'd0;
      perr_q    <= 1'b0;
    end else begin
      cfg_div_q <= cfg_div_d;
      state_q   <= state_d;
      divcnt_q  <= divcnt_d;
      bitidx_q  <= bitidx_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
    end
  end

  // Next-state: a divider write aborts any frame in flight; divcnt restarts on each state entry or bit sample.
  always_comb begin
    fsm_next_s = state_q;
    bitidx_d   = bitidx_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) fsm_next_s = S_START;
        else       fsm_next_s = S_IDLE;
      end
      S_START: begin
        if (sample_s) begin
          if (rx_s) begin
            fsm_next_s = S_IDLE;
          end else begin
            fsm_next_s = S_DATA;
            bitidx_d   = 3'd0;
            perr_d     = 1'b0;
          end
        end else begin
          fsm_next_s = S_START;
        end
      end
      S_DATA: begin
        if (sample_s) begin
          shreg_d  = {rx_s, shreg_q[7:1]};
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) fsm_next_s = DATA_NEXT;
          else                  fsm_next_s = S_DATA;
        end else begin
          fsm_next_s = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample_s) begin
          perr_d     = rx_s ^ even_parity8(shreg_q);
          fsm_next_s = S_STOP;
        end else begin
          fsm_next_s = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (sample_s) begin
          if (rx_s) fsm_next_s = S_IDLE;
          else      fsm_next_s = S_WAITHI;
        end else begin
          fsm_next_s = S_STOP;
        end
      end
      S_WAITHI: begin
        if (rx_s) fsm_next_s = S_IDLE;
        else      fsm_next_s = S_WAITHI;
      end
      default: fsm_next_s = S_IDLE;
    endcase
    state_d  = (reg_div_we != 4'h0) ? S_IDLE : fsm_next_s;
    divcnt_d = ((state_d != state_q) || sample_s) ? 32'd0 : divcnt_q + 32'd1;
  end

  // FSM outputs: sample strobe (half period in START, full period otherwise) and FIFO push.
  always_comb begin
    case (state_q)
      S_START:                  sample_s = (divcnt_q == (cfg_div_q >> 1));
      S_DATA, S_PARITY, S_STOP: sample_s = (divcnt_q == cfg_div_q);
      default:                  sample_s = 1'b0;
    endcase
    push_s      = (state_q == S_STOP) && sample_s;
    push_word_s = {perr_q, ~rx_s, shreg_q};
  end

  assign empty_s = (level_q == {LW{1'b0}});
  assign full_s  = (level_q == FULL_LEVEL);
  assign pop_s   = reg_dat_re && !empty_s;
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // FIFO pointer, level and overrun next-state.
  always_comb begin
    wr_ptr_d = wr_en_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_en_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (pop_s)       overrun_d = 1'b0;
    else if (drop_s) overrun_d = 1'b1;
    else             overrun_d = overrun_q;
  end

  // FIFO control registers; irq is registered from the next level so it tracks rx_level exactly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      level_q   <= {LW{1'b0}};
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
      irq_q     <= (level_d != {LW{1'b0}});
    end
  end

  // FIFO storage: {perr, ferr, data}.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_q[wr_ptr_q] <= push_word_s;
  end

  assign head_s     = mem_q[rd_ptr_q];
  assign reg_dat_do = empty_s ? 32'hFFFF_FFFF : {21'd0, overrun_q, head_s};
  assign reg_div_do = cfg_div_q;
  assign rx_level   = level_q;
  assign rx_irq     = irq_q;

endmodule
